sha256_msg_schedule: RTL and testbench

- Producer side of the per-round (W, K) interface consumed by the SHA-256 round datapath.
- Accepts one 512-bit padded message block and streams the 64 schedule words W[0..63] with matching round constants K[0..63], one pair per handshake.
- Sits between the padding/block buffer and the round iteration logic.
- Owns the 16-word sliding window, the round counter and the K constant ROM.

---
 rtl/sha256_msg_schedule.sv | 122 ++++++++++++
 tb/tb_sha256_msg_schedule.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule producer.
// Takes one 512-bit padded block and streams W[0..63] with K[0..63], one
// (W,K) pair per valid/ready handshake. A 16-word sliding window holds the
// next words, and the head of the window is always the current W[t].
module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [511:0] block_in,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [31:0]  k_out,
    output logic [5:0]   t_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t             state_q, state_d;
    logic [15:0][31:0]  win_q, win_d;     // win_q[0] is the current W[t]
    logic [5:0]         t_q, t_d;
    logic               done_q, done_d;
    logic [31:0]        next_w;

    // Next-state: load on start in IDLE, shift window on each accepted pair
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        t_d     = t_q;
        done_d  = 1'b0;
        next_w  = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = block_in[511 - 32*i -: 32];
                    end
                    t_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_ready) begin
                    if (t_q == LAST_T) begin
                        // Window and t hold; only the state and done change
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        for (int i = 0; i < 15; i++) begin
                            win_d[i] = win_q[i+1];
                        end
                        win_d[15] = next_w;
                        t_d       = t_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, window, round counter and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            t_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            t_q     <= t_d;
            done_q  <= done_d;
        end
    end

    // Outputs depend only on registers (and the ROM indexed by t_q), so
    // w_ready has no combinational path to any output.
    assign w_valid = (state_q == RUN);
    assign busy    = (state_q == RUN);
    assign w_out   = w_valid ? win_q[0] : 32'h0;
    assign k_out   = w_valid ? K_ROM[t_q] : 32'h0;
    assign t_out   = t_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomized bench for sha256_msg_schedule, checked against a plain
// array-based expansion of the SHA-256 schedule recurrence.
module tb_sha256_msg_schedule;

    localparam int ROUNDS = 64;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [511:0] block_in;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [31:0]  k_out;
    logic [5:0]   t_out;
    logic         busy;
    logic         done;

    sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .block_in (block_in),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_out    (w_out),
        .k_out    (k_out),
        .t_out    (t_out),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];
    logic [31:0] got_k [64];

    // Count done pulses shortly after each rising edge
    always @(posedge clk) begin
        #1;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Full 64-word schedule straight from the recurrence
    function automatic void expand(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            exp_w[t] = (rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                     + exp_w[t-7]
                     + (rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                     + exp_w[t-16];
        end
    endfunction

    function automatic logic [511:0] rnd_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Called at a falling edge. Issues start, consumes the stream and returns
    // at the falling edge where done is expected (dly = cycles from the first
    // valid pair to done), or returns early after an abort by reset.
    task automatic run_block(input logic [511:0] blk, input int stall_at, input int stall_len,
                             input int mid_at, input int abort_at, output int dly);
        int  n_acc   = 0;
        int  stalled = 0;
        int  cyc     = 0;
        int  d0;
        bit  rdy;
        expand(blk);
        d0       = done_cnt;
        dly      = -1;
        start    = 1'b1;
        block_in = blk;
        w_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_valid", 32'(w_valid), 1);
        check("first_t", 32'(t_out), 0);
        while (n_acc < ROUNDS && cyc < 400) begin
            start = 1'b0;
            check("valid", 32'(w_valid), 1);
            check("busy", 32'(busy), 1);
            check($sformatf("w[%0d]", n_acc), w_out, exp_w[n_acc]);
            check($sformatf("k[%0d]", n_acc), k_out, k_tab[n_acc]);
            check($sformatf("t[%0d]", n_acc), 32'(t_out), 32'(n_acc));
            if (n_acc == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("abort_valid", 32'(w_valid), 0);
                check("abort_busy", 32'(busy), 0);
                check("abort_t", 32'(t_out), 0);
                check("abort_w", w_out, 0);
                @(negedge clk);
                check("abort_done", 32'(done), 0);
                check("abort_done_cnt", 32'(done_cnt - d0), 0);
                rst_n   = 1'b1;
                w_ready = 1'b1;
                return;
            end
            if (n_acc == mid_at) begin
                start    = 1'b1;
                block_in = rnd_blk();
            end
            rdy = !(n_acc == stall_at && stalled < stall_len);
            if (!rdy) stalled++;
            w_ready = rdy;
            if (rdy) begin
                got_w[n_acc] = w_out;
                got_k[n_acc] = k_out;
                n_acc++;
            end
            @(negedge clk);
            cyc++;
        end
        start   = 1'b0;
        w_ready = 1'b1;
        check("done_pulse", 32'(done), 1);
        check("valid_after_done", 32'(w_valid), 0);
        check("k_after_done", k_out, 0);
        check("done_count", 32'(done_cnt - d0), 1);
        dly = cyc;
    endtask

    logic [511:0] abc;
    int           d;

    initial begin
        abc      = {32'h61626380, 448'h0, 32'h00000018};
        rst_n    = 1'b0;
        start    = 1'b0;
        block_in = '0;
        w_ready  = 1'b0;
        #12;
        check("rst_valid", 32'(w_valid), 0);
        check("rst_w", w_out, 0);
        check("rst_k", k_out, 0);
        check("rst_t", 32'(t_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // "abc" block, no backpressure
        run_block(abc, -1, 0, -1, -1, d);
        check("abc_latency", 32'(d), 64);
        check("abc_w0", got_w[0], 32'h61626380);
        check("abc_k0", got_k[0], 32'h428a2f98);
        check("abc_w15", got_w[15], 32'h00000018);
        check("abc_w16", got_w[16], 32'h61626380);
        check("abc_w17", got_w[17], 32'h000f0000);
        check("abc_k63", got_k[63], 32'hc67178f2);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);

        // Five-cycle stall at t=3
        run_block(abc, 3, 5, -1, -1, d);
        check("stall_latency", 32'(d), 69);
        @(negedge clk);

        // start during RUN is ignored
        run_block(abc, -1, 0, 10, -1, d);
        check("mid_start_w16", got_w[16], 32'h61626380);
        check("mid_start_latency", 32'(d), 64);
        @(negedge clk);

        // Reset mid-block, then a clean restart
        run_block(abc, -1, 0, -1, 20, d);
        @(negedge clk);
        run_block(abc, -1, 0, -1, -1, d);
        check("restart_w0", got_w[0], 32'h61626380);
        @(negedge clk);

        // Back-to-back blocks: start issued in the done cycle
        run_block(rnd_blk(), -1, 0, -1, -1, d);
        run_block(rnd_blk(), -1, 0, -1, -1, d);
        check("b2b_latency", 32'(d), 64);
        run_block(512'h0, -1, 0, -1, -1, d);
        check("zero_w63", got_w[63], 32'h0);
        @(negedge clk);

        // Random blocks with random stalls
        for (int i = 0; i < 4; i++) begin
            int sa, sl;
            sa = $urandom_range(0, 63);
            sl = $urandom_range(1, 4);
            run_block(rnd_blk(), sa, sl, -1, -1, d);
            check("rnd_latency", 32'(d), 32'(64 + sl));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
